// File: rtl/bcci_axis_out_framer_pkg.sv
// Shared types and helpers for the upsampler output framer.
package bcci_out_pkg;

    localparam int unsigned DEF_N_PARALLEL     = 4;
    localparam int unsigned DEF_CHANNEL_WIDTH  = 8;
    localparam int unsigned DEF_N_CHANNEL      = 3;
    localparam int unsigned DEF_OUT_FIFO_DEPTH = 16;
    localparam int unsigned DEF_DIM_WIDTH      = 12;
    localparam int unsigned PIX_W              = DEF_N_CHANNEL * DEF_CHANNEL_WIDTH;
    localparam int unsigned PIX_BYTES          = PIX_W / 8;
    localparam int unsigned DEF_AXIS_DATA_W    = DEF_N_PARALLEL * PIX_W;
    localparam int unsigned MAX_KEEP_W         = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Byte mask covering pixels 0..rem-1 of a beat.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned rem,
                                                        input int unsigned pix_bytes);
        logic [MAX_KEEP_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            if (i < rem * pix_bytes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcci_axis_out_framer_if.sv
// AXI4-Stream bus bundle carrying the framer output.
interface bcci_axis_out_framer_if
    import bcci_out_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_AXIS_DATA_W
);
    logic                  tvalid;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tuser, output tready);
endinterface

// File: rtl/bcci_axis_out_framer_fifo.sv
// First-word fall-through synchronous FIFO; storage is not reset, only pointers.
module bcci_sync_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en_c, rd_en_c;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
    always_comb begin
        wr_en_c  = push && (!full || pop);
        rd_en_c  = pop && !empty;
        wr_ptr_d = wr_en_c ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en_c ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(wr_en_c) - CW'(rd_en_c);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/bcci_axis_out_framer.sv
// Buffers upsampler beats and frames them as AXI4-Stream with tuser/tlast/tkeep.
module bcci_axis_out_framer
    import bcci_out_pkg::*;
#(
    parameter int unsigned N_PARALLEL     = DEF_N_PARALLEL,
    parameter int unsigned CHANNEL_WIDTH  = DEF_CHANNEL_WIDTH,
    parameter int unsigned N_CHANNEL      = DEF_N_CHANNEL,
    parameter int unsigned OUT_FIFO_DEPTH = DEF_OUT_FIFO_DEPTH,
    parameter int unsigned DIM_WIDTH      = DEF_DIM_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIM_WIDTH-1:0]            cfg_width,
    input  logic [DIM_WIDTH-1:0]            cfg_height,
    input  logic                            cfg_start,
    output logic                            cfg_err,
    output logic                            busy,
    input  logic                            upsp_valid,
    input  logic [N_PARALLEL*N_CHANNEL*CHANNEL_WIDTH-1:0] upsp_data,
    output logic                            upsp_ready,
    bcci_axis_out_framer_if.master          m_axis,
    output logic                            interrupt_updone
);
    localparam int unsigned LANE_W             = N_CHANNEL * CHANNEL_WIDTH;
    localparam int unsigned AXISOUT_DATA_WIDTH = N_PARALLEL * LANE_W;
    localparam int unsigned KEEP_W             = AXISOUT_DATA_WIDTH / 8;
    localparam int unsigned LANE_BYTES         = LANE_W / 8;
    localparam int unsigned TOT_W              = 2 * DIM_WIDTH;

    state_e                  state_q, state_d;
    logic [DIM_WIDTH-1:0]    bpl_q, bpl_d;
    logic [DIM_WIDTH-1:0]    rem_q, rem_d;
    logic [DIM_WIDTH-1:0]    height_q, height_d;
    logic [TOT_W-1:0]        total_q, total_d;
    logic [TOT_W-1:0]        in_cnt_q, in_cnt_d;
    logic [DIM_WIDTH-1:0]    col_q, col_d;
    logic [DIM_WIDTH-1:0]    row_q, row_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                          fifo_full, fifo_empty;
    logic [AXISOUT_DATA_WIDTH-1:0] fifo_rd_data;
    logic                          push_c, pop_c, tvalid_c, tlast_c, tuser_c, end_of_line_c;
    logic [DIM_WIDTH-1:0]          bpl_c, rem_c;
    logic [KEEP_W-1:0]             tkeep_c;

    bcci_sync_fifo #(
        .WIDTH (AXISOUT_DATA_WIDTH),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wr_data (upsp_data),
        .pop     (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bpl_c = DIM_WIDTH'((32'(cfg_width) + N_PARALLEL - 1) / N_PARALLEL);
    assign rem_c = DIM_WIDTH'(32'(cfg_width) % N_PARALLEL);

    assign upsp_ready    = (state_q == RUN) && !fifo_full && (in_cnt_q < total_q);
    assign push_c        = upsp_valid && upsp_ready;
    assign tvalid_c      = !fifo_empty;
    assign pop_c         = tvalid_c && m_axis.tready;
    assign end_of_line_c = (col_q == bpl_q - 1'b1);
    assign tlast_c       = tvalid_c && end_of_line_c;
    assign tuser_c       = tvalid_c && (col_q == '0) && (row_q == '0);

    // Partial mask only on the last beat of a line whose width is not a beat multiple.
    always_comb begin
        tkeep_c = '0;
        if (tvalid_c) begin
            tkeep_c = '1;
            if (tlast_c && (rem_q != '0)) tkeep_c = KEEP_W'(keep_mask(32'(rem_q), LANE_BYTES));
        end
    end

    assign m_axis.tvalid = tvalid_c;
    assign m_axis.tdata  = tvalid_c ? fifo_rd_data : '0;
    assign m_axis.tkeep  = tkeep_c;
    assign m_axis.tstrb  = tkeep_c;
    assign m_axis.tlast  = tlast_c;
    assign m_axis.tuser  = tuser_c;

    assign cfg_err          = cfg_err_q;
    assign busy             = busy_q;
    assign interrupt_updone = done_q;

    always_comb begin
        state_d   = state_q;
        bpl_d     = bpl_q;
        rem_d     = rem_q;
        height_d  = height_q;
        total_d   = total_q;
        in_cnt_d  = in_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        cfg_err_d = 1'b0;

        if (push_c) in_cnt_d = in_cnt_q + 1'b1;
        if (pop_c) begin
            if (end_of_line_c) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if ((cfg_width != '0) && (cfg_height != '0)) begin
                        bpl_d    = bpl_c;
                        rem_d    = rem_c;
                        height_d = cfg_height;
                        total_d  = TOT_W'(bpl_c) * TOT_W'(cfg_height);
                        in_cnt_d = '0;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (push_c && (in_cnt_q + 1'b1 == total_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop_c && end_of_line_c && (row_q == height_q - 1'b1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bpl_q     <= '0;
            rem_q     <= '0;
            height_q  <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bpl_q     <= bpl_d;
            rem_q     <= rem_d;
            height_q  <= height_d;
            total_q   <= total_d;
            in_cnt_q  <= in_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cfg_err_q <= cfg_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_bcci_axis_out_framer.sv
// Randomized scoreboard bench for the output framer.
module tb_bcci_axis_out_framer;

    localparam int unsigned DW    = 96;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   cfg_width, cfg_height;
    logic          cfg_start;
    logic          cfg_err, busy;
    logic          upsp_valid;
    logic [DW-1:0] upsp_data;
    logic          upsp_ready;
    logic          interrupt_updone;

    int checks   = 0;
    int failures = 0;

    bcci_axis_out_framer_if #(.DATA_W(DW)) m_axis ();

    bcci_axis_out_framer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .cfg_start        (cfg_start),
        .cfg_err          (cfg_err),
        .busy             (busy),
        .upsp_valid       (upsp_valid),
        .upsp_data        (upsp_data),
        .upsp_ready       (upsp_ready),
        .m_axis           (m_axis),
        .interrupt_updone (interrupt_updone)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected keep for a beat: REM pixels of 3 bytes each on the last beat of a line.
    function automatic logic [KW-1:0] exp_keep(input int col, input int bpl, input int rem);
        logic [KW-1:0] full_mask;
        full_mask = '1;
        if (col == bpl - 1 && rem != 0) return KW'((1 << (rem * 3)) - 1);
        return full_mask;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tvalid"}, 128'(m_axis.tvalid), 128'(0));
        check_eq({tag, "_tdata"},  128'(m_axis.tdata),  128'(0));
        check_eq({tag, "_tkeep"},  128'(m_axis.tkeep),  128'(0));
        check_eq({tag, "_tstrb"},  128'(m_axis.tstrb),  128'(0));
        check_eq({tag, "_tlast"},  128'(m_axis.tlast),  128'(0));
        check_eq({tag, "_tuser"},  128'(m_axis.tuser),  128'(0));
        check_eq({tag, "_ready"},  128'(upsp_ready),    128'(0));
        check_eq({tag, "_busy"},   128'(busy),          128'(0));
        check_eq({tag, "_err"},    128'(cfg_err),       128'(0));
        check_eq({tag, "_irq"},    128'(interrupt_updone), 128'(0));
    endtask

    task automatic run_frame(input int w, input int h, input int vpct, input int rpct,
                             input int stall, input int restart_at);
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        int bpl, rem, total, acc, pops, cyc, k;
        bit irq_seen;
        bpl   = (w + 3) / 4;
        rem   = w % 4;
        total = bpl * h;
        acc = 0; pops = 0; cyc = 0; irq_seen = 0;

        @(negedge clk);
        cfg_width = 12'(w); cfg_height = 12'(h); cfg_start = 1'b1;
        upsp_valid = 1'b0; m_axis.tready = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        check_eq("start_busy", 128'(busy), 128'(1));

        while (!irq_seen && cyc < 3000) begin
            cfg_start  = (cyc == restart_at);
            cfg_width  = (cyc == restart_at) ? 12'd4 : 12'(w);
            cfg_height = (cyc == restart_at) ? 12'd1 : 12'(h);
            upsp_valid = ($urandom_range(99) < vpct);
            upsp_data  = {$urandom, $urandom, $urandom};
            m_axis.tready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rpct);
            #1;
            check_eq("cfg_err_quiet", 128'(cfg_err), 128'(0));
            if (pops == total) begin
                check_eq("irq_pulse", 128'(interrupt_updone), 128'(1));
                check_eq("busy_drop", 128'(busy), 128'(0));
                if (vpct == 100 && rpct == 100 && stall == 0 && restart_at < 0)
                    check_eq("throughput", 128'(cyc), 128'(total + 1));
                irq_seen = 1;
            end else begin
                check_eq("irq_early", 128'(interrupt_updone), 128'(0));
                check_eq("busy", 128'(busy), 128'(1));
                check_eq("upsp_ready", 128'(upsp_ready),
                         128'((acc < total) && (acc - pops < DEPTH)));
                check_eq("tvalid", 128'(m_axis.tvalid), 128'(acc - pops > 0));
                if (upsp_valid && upsp_ready) begin
                    q.push_back(upsp_data);
                    acc++;
                end
                if (m_axis.tvalid && m_axis.tready) begin
                    k = pops;
                    if (q.size() == 0) check_eq("underflow", 128'(1), 128'(0));
                    else begin
                        exp_d = q.pop_front();
                        check_eq("tdata", 128'(m_axis.tdata), 128'(exp_d));
                    end
                    check_eq("tuser", 128'(m_axis.tuser), 128'(k == 0));
                    check_eq("tlast", 128'(m_axis.tlast), 128'((k % bpl) == bpl - 1));
                    check_eq("tkeep", 128'(m_axis.tkeep), 128'(exp_keep(k % bpl, bpl, rem)));
                    check_eq("tstrb", 128'(m_axis.tstrb), 128'(exp_keep(k % bpl, bpl, rem)));
                    pops++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        cfg_start = 1'b0; upsp_valid = 1'b0; m_axis.tready = 1'b0;
        if (!irq_seen) check_eq("frame_timeout", 128'(0), 128'(1));
        check_eq("beats_in", 128'(acc), 128'(total));
        #1;
        check_eq("irq_one_cycle", 128'(interrupt_updone), 128'(0));
        check_eq("busy_after", 128'(busy), 128'(0));
    endtask

    task automatic bad_cfg(input int w, input int h);
        @(negedge clk);
        cfg_width = 12'(w); cfg_height = 12'(h); cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check_eq("bad_err", 128'(cfg_err), 128'(1));
        check_eq("bad_busy", 128'(busy), 128'(0));
        check_eq("bad_ready", 128'(upsp_ready), 128'(0));
        @(negedge clk);
        check_eq("bad_err_clear", 128'(cfg_err), 128'(0));
        check_eq("bad_busy2", 128'(busy), 128'(0));
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        cfg_width = 12'd16; cfg_height = 12'd2; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        m_axis.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            upsp_valid = 1'b1;
            upsp_data  = {$urandom, $urandom, $urandom};
            #1;
            check_eq("rst_pre_ready", 128'(upsp_ready), 128'(1));
            @(negedge clk);
        end
        upsp_valid = 1'b0;
        check_eq("rst_pre_tvalid", 128'(m_axis.tvalid), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("rst_mid");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rst_no_irq", 128'(interrupt_updone), 128'(0));
            check_eq("rst_fifo_empty", 128'(m_axis.tvalid), 128'(0));
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_width = '0; cfg_height = '0; cfg_start = 1'b0;
        upsp_valid = 1'b0; upsp_data = '0; m_axis.tready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(8, 2, 100, 100, 0, -1);
        run_frame(10, 1, 100, 100, 0, -1);
        run_frame(32, 4, 100, 100, 40, -1);
        bad_cfg(8, 0);
        bad_cfg(0, 3);
        run_frame(20, 3, 70, 60, 0, 3);
        reset_mid_frame();
        run_frame(16, 2, 100, 100, 0, -1);
        for (int i = 0; i < 8; i++) begin
            run_frame(int'($urandom_range(40, 1)), int'($urandom_range(4, 1)),
                      int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      int'($urandom_range(10, 0)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcci_axis_out_framer.md
Name: bcci_axis_out_framer

Overview:
- Output-side stream framer for the upsampler, successor to the fixed-geometry output path.
- Accepts N_PARALLEL-pixel beats from the upsampling core and buffers them in an on-chip FIFO.
- Emits an AXI4-Stream master with tuser on start-of-frame, tlast on end-of-line, and tkeep masking on a partial final beat of each line.
- Frame geometry is set at run time; the block raises interrupt_updone once the last beat of a frame has left the interface.

Parameters:
N_PARALLEL, 4, pixels per beat (input and output)
CHANNEL_WIDTH, 8, bits per colour channel
N_CHANNEL, 3, channels per pixel; PIX_W = N_CHANNEL*CHANNEL_WIDTH
OUT_FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
DIM_WIDTH, 12, width of the geometry fields (max 4095 pixels/lines)
AXISOUT_DATA_WIDTH, N_PARALLEL*PIX_W, derived; not overridable

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_width  in  DIM_WIDTH  destination pixels per line; sampled on cfg_start
cfg_height  in  DIM_WIDTH  destination lines per frame; sampled on cfg_start
cfg_start  in  1  one-cycle frame start pulse
cfg_err  out  1  one-cycle pulse: start rejected because width or height is 0
busy  out  1  high from accepted start until the done pulse
upsp_valid  in  1  input beat valid
upsp_data  in  AXISOUT_DATA_WIDTH  pixel 0 in the LSBs
upsp_ready  out  1  input beat ready
m_axis_tvalid  out  1  output valid
m_axis_tdata  out  AXISOUT_DATA_WIDTH  output pixels
m_axis_tkeep  out  AXISOUT_DATA_WIDTH/8  byte keep
m_axis_tstrb  out  AXISOUT_DATA_WIDTH/8  equals tkeep
m_axis_tlast  out  1  last beat of a line
m_axis_tuser  out  1  first beat of a frame
m_axis_tready  in  1  downstream ready
interrupt_updone  out  1  one-cycle frame-done pulse

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0. rst_n low mid-frame discards the FIFO contents and returns to IDLE; no done pulse is issued.
- Derived geometry:
  - BPL = ceil(cfg_width / N_PARALLEL) beats per line.
  - REM = cfg_width mod N_PARALLEL.
  - TOTAL = BPL * cfg_height beats per frame, 2*DIM_WIDTH bits wide.
  - All three are latched at start.
- IDLE:
  - upsp_ready = 0.
  - cfg_start with width != 0 and height != 0: latch geometry, clear counters, go to RUN, set busy in the next cycle.
  - cfg_start with width = 0 or height = 0: pulse cfg_err in the next cycle and stay in IDLE.
- RUN:
  - upsp_ready = !fifo_full && (in_cnt < TOTAL). Readiness is not pop-aware.
  - A beat is accepted on upsp_valid && upsp_ready and increments in_cnt.
  - On the accept that makes in_cnt == TOTAL, go to DRAIN.
- DRAIN:
  - upsp_ready = 0.
  - When the output handshake of beat TOTAL completes, go to DONE.
- DONE: interrupt_updone = 1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
- cfg_start while busy is ignored: no latch, no cfg_err.
- FIFO:
  - Registered first-word fall-through.
  - A beat accepted in cycle N is visible on m_axis_tvalid/tdata in cycle N+1 when the FIFO was empty.
  - Push and pop in the same cycle are allowed at any occupancy, including full: the count is unchanged, data ordering is preserved, and upsp_ready stays low that cycle.
- Output counters col (0..BPL-1) and row (0..cfg_height-1) advance on m_axis_tvalid && m_axis_tready. col wraps to 0 and row increments when col == BPL-1.
- m_axis_tuser = (col == 0 && row == 0).
- m_axis_tlast = (col == BPL-1).
- m_axis_tkeep:
  - All ones except on a tlast beat with REM != 0.
  - On that beat only the bytes of pixels 0..REM-1 are set (PIX_W/8 bytes per pixel); masked-lane tdata is passed through unchanged.
- tvalid/tdata/tkeep/tlast/tuser hold stable while tvalid && !tready (AXIS rule).
- Throughput: with tready held high, one beat per cycle sustained, no bubbles.

Decomposition:
- Package bcci_out_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - function keep_mask(rem) returning the byte mask;
  - localparam PIX_BYTES.
- Sub-module bcci_sync_fifo (parameters WIDTH, DEPTH): FWFT, full/empty/count, synchronous active-low reset. Holds tdata only; tuser/tlast/tkeep are generated from the output counters.

Test Plan:
- Basic frame:
  - Stimulus: width=8, height=2, N_PARALLEL=4, upsp_valid and tready always high.
  - Response: 4 beats with tuser on beat 0, tlast on beats 1 and 3, tkeep=0xFFF on every beat; interrupt_updone pulses once, one cycle after beat 3's handshake.
- Partial beat:
  - Stimulus: width=10, height=1.
  - Response: BPL=3; beat 2 has tlast=1 and tkeep=0x03F (pixels 0-1 only).
- Backpressure:
  - Stimulus: tready low for 40 cycles with depth 16.
  - Response: upsp_ready drops after exactly 16 accepts; no beat lost or duplicated; the output sequence equals the input sequence.
- Bad config:
  - Stimulus: cfg_start with height=0.
  - Response: cfg_err pulses once, busy stays 0, upsp_ready stays 0.
- Start while busy:
  - Stimulus: a second cfg_start mid-frame with width=4.
  - Response: ignored; the original geometry is used to completion.
- Reset mid-frame:
  - Stimulus: rst_n low for 1 cycle after 5 of 8 beats.
  - Response: next cycle all outputs 0, FIFO empty, no interrupt_updone; a new frame then runs normally.
